// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon permutation controller: FSM states,
// round-count limits and the 320-bit state layout.
package ascon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam logic [3:0] ROUNDS_MAX = 4'd12;
  localparam logic [3:0] LAST_RC    = 4'd11;

  // x0 occupies the top 64 bits, matching the {x0,x1,x2,x3,x4} bus packing.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  // p^n runs the last n rounds of p^12, so the counter starts at 12-n.
  // Out-of-range requests (0 or >12) fall back to the default round count.
  function automatic logic [3:0] rounds_to_start_rc(input logic [3:0] nr,
                                                    input logic [3:0] def_rounds);
    logic [3:0] eff;
    eff = ((nr == 4'd0) || (nr > ROUNDS_MAX)) ? def_rounds : nr;
    return ROUNDS_MAX - eff;
  endfunction

endpackage

// File: rtl/asconp_lut_ctrl.sv
// Round scheduler and S-box LUT write arbiter for the LUT-based Ascon
// permutation datapath; owns the 320-bit state register and round counter.
module asconp_lut_ctrl
  import ascon_pkg::*;
#(
  parameter int DEF_ROUNDS = 12,
  parameter int LUT_ADDR_W = 5,
  parameter int LUT_DATA_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  perm_valid_i,
  output logic                  perm_ready_o,
  input  logic [3:0]            perm_rounds_i,
  input  logic [319:0]          state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [319:0]          state_o,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [LUT_ADDR_W-1:0] cfg_addr_i,
  input  logic [LUT_DATA_W-1:0] cfg_data_i,
  output logic                  busy_o,
  output logic [3:0]            dp_round_cnt_o,
  output logic [63:0]           dp_x0_o,
  output logic [63:0]           dp_x1_o,
  output logic [63:0]           dp_x2_o,
  output logic [63:0]           dp_x3_o,
  output logic [63:0]           dp_x4_o,
  input  logic [63:0]           dp_x0_i,
  input  logic [63:0]           dp_x1_i,
  input  logic [63:0]           dp_x2_i,
  input  logic [63:0]           dp_x3_i,
  input  logic [63:0]           dp_x4_i,
  output logic                  dp_upd_sbox_o,
  output logic [LUT_ADDR_W-1:0] dp_sbox_addr_o,
  output logic [LUT_DATA_W-1:0] dp_sbox_data_o
);

  ctrl_state_e           state_q, state_d;
  ascon_state_t          st_q;
  ascon_state_t          dp_next;
  logic [3:0]            rc_q;
  logic [LUT_ADDR_W-1:0] sbox_addr_q;
  logic [LUT_DATA_W-1:0] sbox_data_q;
  logic                  perm_fire;
  logic                  cfg_fire;

  assign dp_next = {dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Readies depend only on state, except perm_ready_o in IDLE,
  // which drops while cfg_valid_i is high so a LUT write wins a tie.
  always_comb begin
    state_d      = state_q;
    perm_ready_o = 1'b0;
    cfg_ready_o  = 1'b0;
    out_valid_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_o  = 1'b1;
        perm_ready_o = !cfg_valid_i;
        if (cfg_valid_i) begin
          state_d = ST_CFG;
        end else if (perm_valid_i) begin
          state_d = ST_RUN;
        end
      end
      ST_CFG: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (rc_q == LAST_RC) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign perm_fire = perm_valid_i & perm_ready_o;
  assign cfg_fire  = cfg_valid_i & cfg_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= '0;
      rc_q        <= '0;
      sbox_addr_q <= '0;
      sbox_data_q <= '0;
    end else begin
      if (cfg_fire) begin
        sbox_addr_q <= cfg_addr_i;
        sbox_data_q <= cfg_data_i;
      end
      if (perm_fire) begin
        st_q <= state_i;
        rc_q <= rounds_to_start_rc(perm_rounds_i, 4'(DEF_ROUNDS));
      end else if (state_q == ST_RUN) begin
        st_q <= dp_next;
        // Counter parks at the last round index rather than wrapping.
        if (rc_q != LAST_RC) begin
          rc_q <= rc_q + 4'd1;
        end
      end
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign dp_round_cnt_o = (state_q == ST_RUN) ? rc_q : 4'd0;
  assign dp_upd_sbox_o  = (state_q == ST_CFG);
  assign dp_sbox_addr_o = sbox_addr_q;
  assign dp_sbox_data_o = sbox_data_q;

  assign state_o = st_q;
  assign dp_x0_o = st_q.x0;
  assign dp_x1_o = st_q.x1;
  assign dp_x2_o = st_q.x2;
  assign dp_x3_o = st_q.x3;
  assign dp_x4_o = st_q.x4;

endmodule

// File: tb/tb_asconp_lut_ctrl.sv
// Bench for asconp_lut_ctrl: a behavioural Ascon round stands in for the
// datapath; a monitor pops expected results and LUT writes from queues.
module tb_asconp_lut_ctrl;

  localparam int AW = 5;
  localparam int DW = 20;

  localparam logic [319:0] S1 = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                 64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0,
                                 64'h00000080400c0600};
  localparam logic [319:0] S2 = {64'hdeadbeefcafef00d, 64'h0000000000000001,
                                 64'h8000000000000000, 64'h5555aaaa5555aaaa,
                                 64'hffffffff00000000};

  logic           clk = 1'b0;
  logic           rst;
  logic           perm_valid_i;
  logic           perm_ready_o;
  logic [3:0]     perm_rounds_i;
  logic [319:0]   state_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [319:0]   state_o;
  logic           cfg_valid_i;
  logic           cfg_ready_o;
  logic [AW-1:0]  cfg_addr_i;
  logic [DW-1:0]  cfg_data_i;
  logic           busy_o;
  logic [3:0]     dp_round_cnt_o;
  logic [63:0]    dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o;
  logic [63:0]    dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i;
  logic           dp_upd_sbox_o;
  logic [AW-1:0]  dp_sbox_addr_o;
  logic [DW-1:0]  dp_sbox_data_o;

  int n_cmp = 0;
  int n_fail = 0;
  int n_out_pops = 0;
  logic [319:0]     exp_q[$];
  logic [AW+DW-1:0] cfg_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  asconp_lut_ctrl #(.DEF_ROUNDS(12), .LUT_ADDR_W(AW), .LUT_DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .perm_valid_i(perm_valid_i), .perm_ready_o(perm_ready_o),
    .perm_rounds_i(perm_rounds_i), .state_i(state_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .state_o(state_o),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .busy_o(busy_o), .dp_round_cnt_o(dp_round_cnt_o),
    .dp_x0_o(dp_x0_o), .dp_x1_o(dp_x1_o), .dp_x2_o(dp_x2_o),
    .dp_x3_o(dp_x3_o), .dp_x4_o(dp_x4_o),
    .dp_x0_i(dp_x0_i), .dp_x1_i(dp_x1_i), .dp_x2_i(dp_x2_i),
    .dp_x3_i(dp_x3_i), .dp_x4_i(dp_x4_i),
    .dp_upd_sbox_o(dp_upd_sbox_o), .dp_sbox_addr_o(dp_sbox_addr_o),
    .dp_sbox_data_o(dp_sbox_data_o)
  );

  // ---------------- reference round ----------------
  function automatic logic [7:0] rc_const(input logic [3:0] rc);
    return 8'hf0 - {rc, 4'h0} + {4'h0, rc};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rc);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, rc_const(rc)};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] ascon_perm(input logic [319:0] s, input int start);
    logic [319:0] v;
    v = s;
    for (int r = start; r < 12; r++) v = ascon_round(v, 4'(r));
    return v;
  endfunction

  assign {dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i} =
    ascon_round({dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o}, dp_round_cnt_o);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else check("state_o", state_o, exp_q.pop_front());
        n_out_pops++;
      end
      if (dp_upd_sbox_o) begin
        if (cfg_q.size() == 0) fail_now("unexpected_sbox_write");
        else check("sbox_write", {dp_sbox_addr_o, dp_sbox_data_o}, cfg_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic do_perm(input logic [319:0] st, input logic [3:0] rounds,
                         input int exp_nr, input logic [7:0] exp_c0,
                         input int hold, output int waited);
    logic [319:0] exp_val;
    bit ok;
    @(posedge clk); #1;
    state_i = st; perm_rounds_i = rounds; perm_valid_i = 1'b1;
    waited = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (perm_ready_o) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      fail_now("perm_accept_timeout");
      perm_valid_i = 1'b0;
      return;
    end
    exp_val = ascon_perm(st, 12 - exp_nr);
    exp_q.push_back(exp_val);
    @(posedge clk); #1;
    perm_valid_i = 1'b0;
    for (int k = 0; k < exp_nr; k++) begin
      @(negedge clk);
      check("rc_step", {dp_round_cnt_o, out_valid_o}, {4'(12 - exp_nr + k), 1'b0});
      if (k == 0) check("rc_const", rc_const(dp_round_cnt_o), exp_c0);
    end
    @(negedge clk);
    check("latency", out_valid_o, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_state", state_o, exp_val);
        check("hold_valid", out_valid_o, 1);
      end
      @(posedge clk); #1;
      out_ready_i = 1'b1;
    end
    wait_idle();
  endtask

  task automatic do_cfg(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waited, output bit stall_ok);
    bit ok;
    @(posedge clk); #1;
    cfg_addr_i = a; cfg_data_i = d; cfg_valid_i = 1'b1;
    waited = 0; stall_ok = 1'b1; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_ready_o) begin
        if (busy_o) stall_ok = 1'b0;
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      fail_now("cfg_accept_timeout");
      cfg_valid_i = 1'b0;
      return;
    end
    cfg_q.push_back({a, d});
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int  w, wc, pops0;
  bit  sok, hit;

  initial begin
    rst = 1'b1; perm_valid_i = 1'b0; perm_rounds_i = '0; state_i = '0;
    out_ready_i = 1'b1; cfg_valid_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_ctrl", {out_valid_o, busy_o, dp_upd_sbox_o, dp_round_cnt_o, perm_ready_o, cfg_ready_o},
          {1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1});
    check("reset_state", state_o, 0);
    check("reset_sbox", {dp_sbox_addr_o, dp_sbox_data_o}, 0);

    do_perm(320'h0, 4'd12, 12, 8'hf0, 0, w);
    check("p12_accept_wait", w, 0);
    do_perm(S1, 4'd8, 8, 8'hb4, 0, w);
    do_perm(S2, 4'd6, 6, 8'h96, 0, w);
    do_perm(S1, 4'd0, 12, 8'hf0, 0, w);
    do_perm(S1, 4'd13, 12, 8'hf0, 0, w);

    // Tie in IDLE: LUT write first, permutation two edges later.
    fork
      do_cfg(5'h1f, 20'habcde, wc, sok);
      do_perm(S2, 4'd12, 12, 8'hf0, 0, w);
    join
    check("tie_cfg_wait", wc, 0);
    check("tie_perm_wait", w, 2);

    // LUT write requested mid-run stalls until the result is taken.
    pops0 = n_out_pops;
    fork
      do_perm(S1, 4'd12, 12, 8'hf0, 0, w);
      begin
        repeat (4) @(posedge clk);
        do_cfg(5'h0a, 20'h12345, wc, sok);
        check("cfg_after_done", n_out_pops, pops0 + 1);
      end
    join
    check("cfg_stall_ok", sok, 1);
    check("cfg_stall_wait", wc, 10);

    // Asynchronous reset while rc == 5.
    @(posedge clk); #1;
    state_i = S2; perm_rounds_i = 4'd12; perm_valid_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (perm_ready_o) begin
        hit = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    perm_valid_i = 1'b0;
    if (!hit) fail_now("rst_perm_accept");
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dp_round_cnt_o == 4'd5) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) fail_now("rst_reach_rc5");
    #1 rst = 1'b1;
    #1;
    check("midrst_ctrl", {out_valid_o, busy_o, dp_upd_sbox_o, dp_round_cnt_o}, 0);
    check("midrst_state", state_o, 0);
    check("midrst_sbox", {dp_sbox_addr_o, dp_sbox_data_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy_o, perm_ready_o}, 2'b01);
    do_perm(S2, 4'd12, 12, 8'hf0, 0, w);

    // Consumer stalls for 10 cycles in DONE.
    out_ready_i = 1'b0;
    do_perm(S1, 4'd8, 8, 8'hb4, 10, w);

    repeat (3) @(negedge clk);
    check("queues_empty", exp_q.size() + cfg_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
